// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (multiplier and
// restoring divider): FSM state encoding, default operand widths and the
// fractional-bit count of the Q-format operands.
package shift_add_multiplier_pkg;

   // Common sequencer encoding shared with the divider.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int A_W_DEF = 20;  // multiplicand width, unsigned Q10.10
   localparam int B_W_DEF = 3;   // multiplier width, unsigned integer
   localparam int FRAC_W  = 10;  // fractional bits of the fixed-point operands

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: unsigned Q10.10 multiplicand times a small
// unsigned integer, exact Q13.10 product. One multiplier bit is consumed per
// cycle, stopping early once the remaining multiplier bits are all zero.
//
// Handshake: in_valid is a one-cycle start pulse whose operands are sampled
// on the same rising edge; it is honoured only in IDLE and ignored otherwise.
// out_valid is a one-cycle pulse, out_data is valid while it is high and then
// holds that result until the next completion. There is no ready signal.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int A_W = A_W_DEF,
   parameter int B_W = B_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [A_W-1:0]       in_data_1,
   input  logic [B_W-1:0]       in_data_2,
   output logic                 out_valid,
   output logic [A_W+B_W-1:0]   out_data
);

   localparam int P_W   = A_W + B_W;
   localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

   state_t             state;
   state_t             state_next;
   logic [P_W-1:0]     acc;
   logic [P_W-1:0]     mcand;
   logic [B_W-1:0]     mplr;
   logic [CNT_W-1:0]   cnt;
   logic [P_W-1:0]     acc_sum;
   logic               last_step;

   // Sequencer state register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode plus the per-step addend and termination test.
   always_comb begin
      state_next = state;
      acc_sum    = acc + (mplr[0] ? mcand : '0);
      last_step  = ((mplr >> 1) == '0) || (cnt == CNT_LAST);
      case (state)
         IDLE:    if (in_valid) state_next = MULT;
         MULT:    if (last_step) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand load, shift-add iteration and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         mcand     <= '0;
         mplr      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand <= {{B_W{1'b0}}, in_data_1};
                  mplr  <= in_data_2;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            MULT: begin
               acc   <= acc_sum;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + 1'b1;
               // The final addend is folded in here so the product is ready
               // on the same edge the sequencer leaves MULT.
               if (last_step) begin
                  out_data  <= acc_sum;
                  out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
